// File: rtl/gray_frame_writer.sv
// gray_frame_writer
// Moves one frame of 8-bit grayscale pixels from an upstream first-word-fall-through
// FIFO into a downstream 24-bit pixel FIFO. Each gray byte is copied into all three
// colour bytes. The block tracks the column and row of the next pixel to transfer.
//
// Ports
//   clock      in   single clock; all state changes on its rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   single-cycle request to transfer one frame (used only in IDLE)
//   done       out  one-cycle pulse in the cycle after the frame's last pixel is written
//   in_rd_en   out  read strobe to the upstream FIFO (combinational)
//   in_empty   in   upstream FIFO empty flag
//   in_dout    in   upstream FIFO head data (8-bit gray)
//   out_wr_en  out  write strobe to the downstream FIFO (combinational)
//   out_full   in   downstream FIFO full flag
//   out_din    out  downstream pixel data {gray, gray, gray} (combinational)
//   col        out  column index of the next pixel to transfer
//   row        out  row index of the next pixel to transfer
module gray_frame_writer #(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [7:0]  in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [23:0] out_din,
  output logic [9:0]  col,
  output logic [9:0]  row
);

  // 10-bit counters cover frame sizes up to 1023 x 1023.
  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          xfer_c;

  // A pixel moves when both FIFOs are ready; reset gates the strobes directly so they
  // drop the moment reset rises, not only after the state register clears.
  assign xfer_c    = (state_q == RUN) && !in_empty && !out_full && !reset;
  assign in_rd_en  = xfer_c;
  assign out_wr_en = xfer_c;
  assign out_din   = {in_dout, in_dout, in_dout};

  assign done = (state_q == DONE);
  assign col  = col_q;
  assign row  = row_q;

  // State and position registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next-state and position update; stall cycles fall through the defaults.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer_c) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/gray_frame_writer.md
GRAY_FRAME_WRITER -- requirements
Module: gray_frame_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 720, pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 540, rows per frame.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to transfer one frame.
REQ-006 SHALL have port done  output  1  one-cycle pulse when the frame's last pixel is written.
REQ-007 SHALL have port in_rd_en  output  1  read strobe to the upstream 8-bit grayscale FIFO.
REQ-008 SHALL have port in_empty  input  1  upstream FIFO empty flag.
REQ-009 SHALL have port in_dout  input  8  upstream FIFO head data, first-word-fall-through.
REQ-010 SHALL have port out_wr_en  output  1  write strobe to the downstream 24-bit pixel FIFO.
REQ-011 SHALL have port out_full  input  1  downstream FIFO full flag.
REQ-012 SHALL have port out_din  output  24  downstream pixel data.
REQ-013 SHALL have port col  output  10  column index of the next pixel to transfer.
REQ-014 SHALL have port row  output  10  row index of the next pixel to transfer.

Function
REQ-015 SHALL implement three states: IDLE, RUN, DONE.
REQ-016 SHALL move IDLE -> RUN on start=1; start SHALL be ignored in RUN and DONE.
REQ-017 SHALL, in RUN, transfer one pixel in each cycle where in_empty=0 and out_full=0; no transfer otherwise.
REQ-018 SHALL drive in_rd_en = out_wr_en = (state==RUN && !in_empty && !out_full), combinationally, with zero-cycle latency.
REQ-019 SHALL drive out_din = {in_dout, in_dout, in_dout} (gray replicated to B,G,R bytes) combinationally.
REQ-020 SHALL never assert in_rd_en or out_wr_en outside RUN, nor when in_empty=1 or out_full=1.
REQ-021 SHALL increment col on each transfer; on col==WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-022 SHALL, on the transfer with col==WIDTH-1 and row==HEIGHT-1, clear col and row to 0 and move RUN -> DONE.
REQ-023 SHALL assert done for exactly the one cycle spent in DONE, then move DONE -> IDLE.
REQ-024 SHALL transfer exactly WIDTH*HEIGHT pixels per start; no pixel SHALL be read after the last of the frame until a new start.
REQ-025 SHALL hold col, row and state unchanged during stall cycles (in_empty=1 or out_full=1).
REQ-026 SHALL use counters wide enough for WIDTH, HEIGHT up to 1023 without overflow.

Reset
REQ-027 SHALL, on reset=1, go to IDLE immediately and set col=0, row=0, done=0, regardless of clock.
REQ-028 SHALL, while reset=1, hold in_rd_en=0 and out_wr_en=0.
REQ-029 SHALL, on reset mid-frame, discard progress; the next start SHALL begin at row 0, col 0.

Verification
REQ-030 Bench SHALL check reset: assert reset mid-cycle -> state IDLE, col=0, row=0, done=0, strobes 0 before next clock edge.
REQ-031 Bench SHALL check full frame: start, upstream never empty, downstream never full -> 388800 writes on consecutive cycles, done pulses one cycle after the last write, every out_din = {3{in_dout}}.
REQ-032 Bench SHALL check stalls: random in_empty and out_full (about 30% each) -> strobes never high while either flag is high; output sequence and count identical to the no-stall run.
REQ-033 Bench SHALL check row wrap: after 720 transfers -> col=0, row=1; after 719 transfers -> col=719, row=0.
REQ-034 Bench SHALL check start handling: start during RUN -> ignored and count unchanged; start in IDLE with in_empty=1 -> RUN, no strobes until data arrives.
REQ-035 Bench SHALL check reset mid-frame: reset after 1000 transfers, then start -> transfers restart at col 0, row 0, and 388800 more writes precede done.
